// File: rtl/adel_seq_ctrl.sv
// Run-control sequencer and program store for the adel core; inst_o is combinational, control outputs are registered.
// Commands are accepted in IDLE/RUN/STEP (cmd_ready low only while the core reset is held in CRST).
module adel_seq_ctrl #(
  parameter int DEPTH = 32,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [15:0]   cmd_data,
  input  logic [7:0]    pc_i,
  output logic [15:0]   inst_o,
  output logic          core_en,
  output logic          core_nrst,
  output logic          running,
  output logic          bp_hit,
  output logic          cmd_err,
  output logic [CW-1:0] cyc_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_SET_WPTR = 3'd1;
  localparam logic [2:0] OP_WRITE    = 3'd2;
  localparam logic [2:0] OP_RUN      = 3'd3;
  localparam logic [2:0] OP_HALT     = 3'd4;
  localparam logic [2:0] OP_STEP     = 3'd5;
  localparam logic [2:0] OP_SET_BP   = 3'd6;
  localparam logic [2:0] OP_CORE_RST = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_CRST} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic            bp_en_q, bp_en_d;
  logic [7:0]      bp_addr_q, bp_addr_d;
  logic [7:0]      step_cnt_q, step_cnt_d;
  logic [CW-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic            bp_hit_q, bp_hit_d;
  logic            cmd_err_q, cmd_err_d;
  logic            first_q, first_d;
  logic            core_nrst_q, core_nrst_d;
  logic            crst_cnt_q, crst_cnt_d;
  logic            mem_we;
  logic            acc;
  logic            exec_st;
  logic            bp_match;
  logic [15:0]     mem_q [DEPTH];

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    bp_en_d     = bp_en_q;
    bp_addr_d   = bp_addr_q;
    step_cnt_d  = step_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    bp_hit_d    = bp_hit_q;
    cmd_err_d   = 1'b0;
    first_d     = first_q;
    crst_cnt_d  = crst_cnt_q;
    mem_we      = 1'b0;

    exec_st   = (state_q == S_RUN) || (state_q == S_STEP);
    // first suppresses the match so a run started at bp_addr executes it
    bp_match  = exec_st && bp_en_q && (pc_i == bp_addr_q) && !first_q;
    core_en   = exec_st && !bp_match;
    cmd_ready = (state_q != S_CRST);
    acc       = cmd_valid && cmd_ready;

    if (core_en) cyc_cnt_d = cyc_cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (acc) begin
          case (cmd_op)
            OP_SET_WPTR: wptr_d = cmd_data[AW-1:0];
            OP_WRITE: begin
              mem_we = 1'b1;
              wptr_d = wptr_q + AW'(1);
            end
            OP_RUN: begin
              state_d  = S_RUN;
              first_d  = 1'b1;
              bp_hit_d = 1'b0;
            end
            OP_STEP: begin
              if (cmd_data[7:0] != 8'd0) begin
                state_d    = S_STEP;
                step_cnt_d = cmd_data[7:0];
                first_d    = 1'b1;
                bp_hit_d   = 1'b0;
              end
            end
            OP_CORE_RST: begin
              state_d    = S_CRST;
              crst_cnt_d = 1'b0;
              cyc_cnt_d  = '0;
            end
            default: ;
          endcase
        end
      end
      S_RUN, S_STEP: begin
        first_d = 1'b0;
        if (bp_match) begin
          state_d  = S_IDLE;
          bp_hit_d = 1'b1;
        end else if (acc && (cmd_op == OP_HALT)) begin
          state_d = S_IDLE;
        end else if (state_q == S_STEP) begin
          step_cnt_d = step_cnt_q - 8'd1;
          if (step_cnt_q == 8'd1) state_d = S_IDLE;
        end
        if (acc && !((cmd_op == OP_NOP) || (cmd_op == OP_HALT) || (cmd_op == OP_SET_BP)))
          cmd_err_d = 1'b1;
      end
      S_CRST: begin
        if (crst_cnt_q) state_d = S_IDLE;
        else crst_cnt_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (acc && (cmd_op == OP_SET_BP)) begin
      bp_addr_d = cmd_data[7:0];
      bp_en_d   = cmd_data[8];
    end

    // registered so core_nrst is low exactly while the state register holds CRST
    core_nrst_d = (state_d != S_CRST);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      bp_en_q     <= 1'b0;
      bp_addr_q   <= '0;
      step_cnt_q  <= '0;
      cyc_cnt_q   <= '0;
      bp_hit_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      first_q     <= 1'b0;
      core_nrst_q <= 1'b0;
      crst_cnt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      bp_en_q     <= bp_en_d;
      bp_addr_q   <= bp_addr_d;
      step_cnt_q  <= step_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      bp_hit_q    <= bp_hit_d;
      cmd_err_q   <= cmd_err_d;
      first_q     <= first_d;
      core_nrst_q <= core_nrst_d;
      crst_cnt_q  <= crst_cnt_d;
    end
  end

  // program store deliberately has no reset so a loaded program survives nrst
  always_ff @(posedge clk) begin
    if (nrst && mem_we) mem_q[wptr_q] <= cmd_data;
  end

  assign inst_o    = mem_q[pc_i[AW-1:0]];
  assign core_nrst = core_nrst_q;
  assign running   = exec_st;
  assign bp_hit    = bp_hit_q;
  assign cmd_err   = cmd_err_q;
  assign cyc_cnt   = cyc_cnt_q;
endmodule

// File: tb/tb_adel_seq_ctrl.sv
// Scoreboarded bench for adel_seq_ctrl: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_adel_seq_ctrl;
  localparam int DEPTH = 32;
  localparam int CW    = 16;

  localparam logic [2:0] OP_NOP = 3'd0, OP_SET_WPTR = 3'd1, OP_WRITE = 3'd2, OP_RUN = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd4, OP_STEP = 3'd5, OP_SET_BP = 3'd6, OP_CORE_RST = 3'd7;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [15:0]   cmd_data = 16'd0;
  logic [7:0]    pc_i = 8'd0;
  logic [15:0]   inst_o;
  logic          core_en, core_nrst, running, bp_hit, cmd_err;
  logic [CW-1:0] cyc_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] model_mem [DEPTH];
  int          mptr = 0;
  int          exp_cyc = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp;

  adel_seq_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .pc_i(pc_i), .inst_o(inst_o),
    .core_en(core_en), .core_nrst(core_nrst), .running(running),
    .bp_hit(bp_hit), .cmd_err(cmd_err), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // present one command and hold it until the accepting posedge
  task automatic cmd(input logic [2:0] op, input logic [15:0] d);
    int t;
    t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_ready_timeout: op %0d never accepted", op);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 16'd0;
  endtask

  task automatic load(input logic [15:0] d);
    model_mem[mptr] = d;
    mptr = (mptr + 1) % DEPTH;
    cmd(OP_WRITE, d);
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL rst_running: got %b want 0", running); end
    n_cmp++; if (core_en !== 1'b0) begin n_bad++; $display("FAIL rst_core_en: got %b want 0", core_en); end
    n_cmp++; if (core_nrst !== 1'b0) begin n_bad++; $display("FAIL rst_core_nrst: got %b want 0", core_nrst); end
    n_cmp++; if (bp_hit !== 1'b0) begin n_bad++; $display("FAIL rst_bp_hit: got %b want 0", bp_hit); end
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_err: got %b want 0", cmd_err); end
    n_cmp++; if (cyc_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cyc_cnt: got %0d want 0", cyc_cnt); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    n_cmp++; if (core_nrst !== 1'b0) begin n_bad++; $display("FAIL rst_core_nrst_first_edge: got %b want 0", core_nrst); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (core_nrst !== 1'b1) begin n_bad++; $display("FAIL rst_core_nrst_release: got %b want 1", core_nrst); end
    exp_cyc = 0;
  endtask

  task automatic test_load;
    int addrs [6];
    addrs = '{30, 31, 0, 1, 33, 2};
    cmd(OP_SET_WPTR, 16'd30);
    mptr = 30;
    load(16'hA0A0); load(16'hB1B1); load(16'hC2C2); load(16'hD3D3);
    load(16'hE4E4);
    for (int i = 0; i < 6; i++) begin
      pc_i = 8'(addrs[i]);
      exp_q.push_back(model_mem[addrs[i] % DEPTH]);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_cmp++; if (inst_o !== exp) begin n_bad++; $display("FAIL load_read pc=%0d: got %h want %h", addrs[i], inst_o, exp); end
      @(posedge clk); #1;
    end
    pc_i = 8'd3;
    exp_q.push_back(16'hF5F5);
    load(16'hF5F5);
    @(negedge clk);
    exp = exp_q.pop_front();
    n_cmp++; if (inst_o !== exp) begin n_bad++; $display("FAIL load_write_through: got %h want %h", inst_o, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_step;
    int en;
    pc_i = 8'd0;
    cmd(OP_STEP, 16'd3);
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL step_running: got %b want 1", running); end
    en = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (core_en === 1'b1) en++;
      @(posedge clk); #1;
    end
    exp_cyc += 3;
    n_cmp++; if (en != 3) begin n_bad++; $display("FAIL step3_en_cycles: got %0d want 3", en); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL step3_running_after: got %b want 0", running); end
    n_cmp++; if (cyc_cnt !== 16'(exp_cyc)) begin n_bad++; $display("FAIL step3_cyc_cnt: got %0d want %0d", cyc_cnt, exp_cyc); end
    cmd(OP_STEP, 16'd0);
    @(negedge clk);
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL step0_cmd_err: got %b want 0", cmd_err); end
    en = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (core_en === 1'b1) en++;
      @(posedge clk); #1;
    end
    n_cmp++; if (en != 0) begin n_bad++; $display("FAIL step0_en_cycles: got %0d want 0", en); end
    n_cmp++; if (cyc_cnt !== 16'(exp_cyc)) begin n_bad++; $display("FAIL step0_cyc_cnt: got %0d want %0d", cyc_cnt, exp_cyc); end
  endtask

  task automatic test_breakpoint;
    cmd(OP_SET_BP, 16'h0105);
    pc_i = 8'd0;
    cmd(OP_RUN, 16'd0);
    for (int k = 0; k < 6; k++) begin
      pc_i = 8'(k);
      @(negedge clk);
      n_cmp++; if (core_en !== (k < 5)) begin n_bad++; $display("FAIL bp_sweep_en pc=%0d: got %b want %b", k, core_en, (k < 5)); end
      @(posedge clk); #1;
    end
    exp_cyc += 5;
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL bp_stop_running: got %b want 0", running); end
    n_cmp++; if (bp_hit !== 1'b1) begin n_bad++; $display("FAIL bp_hit_set: got %b want 1", bp_hit); end
    n_cmp++; if (cyc_cnt !== 16'(exp_cyc)) begin n_bad++; $display("FAIL bp_cyc_cnt: got %0d want %0d", cyc_cnt, exp_cyc); end
    cmd(OP_RUN, 16'd0);
    @(negedge clk);
    n_cmp++; if (core_en !== 1'b1) begin n_bad++; $display("FAIL bp_resume_en: got %b want 1", core_en); end
    n_cmp++; if (bp_hit !== 1'b0) begin n_bad++; $display("FAIL bp_resume_hit_clr: got %b want 0", bp_hit); end
    @(posedge clk); #1;
    pc_i = 8'd6;
    cmd(OP_HALT, 16'd0);
    exp_cyc += 2;
    n_cmp++; if (cyc_cnt !== 16'(exp_cyc)) begin n_bad++; $display("FAIL bp_resume_cyc_cnt: got %0d want %0d", cyc_cnt, exp_cyc); end
    // breakpoint and HALT in the same cycle
    pc_i = 8'd0;
    cmd(OP_RUN, 16'd0);
    @(posedge clk); #1;
    exp_cyc += 1;
    pc_i = 8'd5;
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    @(negedge clk);
    n_cmp++; if (core_en !== 1'b0) begin n_bad++; $display("FAIL bp_halt_en: got %b want 0", core_en); end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    n_cmp++; if (bp_hit !== 1'b1) begin n_bad++; $display("FAIL bp_halt_hit: got %b want 1", bp_hit); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL bp_halt_running: got %b want 0", running); end
    n_cmp++; if (cyc_cnt !== 16'(exp_cyc)) begin n_bad++; $display("FAIL bp_halt_cyc_cnt: got %0d want %0d", cyc_cnt, exp_cyc); end
  endtask

  task automatic test_halt;
    int en;
    int addrs [2];
    cmd(OP_SET_BP, 16'h0000);
    cmd(OP_SET_WPTR, 16'd1);
    mptr = 1;
    pc_i = 8'd0;
    cmd(OP_RUN, 16'd0);
    en = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) begin cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_data = 16'hDEAD; end
      if (i == 10) begin cmd_valid = 1'b1; cmd_op = OP_HALT; end
      @(negedge clk);
      if (core_en === 1'b1) en++;
      if (i == 4) begin
        n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL halt_write_err_pulse: got %b want 1", cmd_err); end
      end
      if (i == 5) begin
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL halt_write_err_clear: got %b want 0", cmd_err); end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 16'd0;
    end
    exp_cyc += 11;
    n_cmp++; if (en != 11) begin n_bad++; $display("FAIL halt_en_cycles: got %0d want 11", en); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL halt_running: got %b want 0", running); end
    n_cmp++; if (cyc_cnt !== 16'(exp_cyc)) begin n_bad++; $display("FAIL halt_cyc_cnt: got %0d want %0d", cyc_cnt, exp_cyc); end
    pc_i = 8'd1;
    exp_q.push_back(model_mem[1]);
    @(negedge clk);
    exp = exp_q.pop_front();
    n_cmp++; if (inst_o !== exp) begin n_bad++; $display("FAIL halt_mem_unchanged: got %h want %h", inst_o, exp); end
    @(posedge clk); #1;
    load(16'h1234);
    addrs = '{1, 2};
    for (int i = 0; i < 2; i++) begin
      pc_i = 8'(addrs[i]);
      exp_q.push_back(model_mem[addrs[i]]);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_cmp++; if (inst_o !== exp) begin n_bad++; $display("FAIL halt_wptr_kept pc=%0d: got %h want %h", addrs[i], inst_o, exp); end
      @(posedge clk); #1;
    end
    cmd(OP_HALT, 16'd0);
    @(negedge clk);
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL idle_halt_err: got %b want 0", cmd_err); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL idle_halt_running: got %b want 0", running); end
    @(posedge clk); #1;
  endtask

  task automatic test_core_rst;
    logic exp_lvl [3];
    exp_lvl = '{1'b0, 1'b0, 1'b1};
    cmd(OP_CORE_RST, 16'd0);
    exp_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (core_nrst !== exp_lvl[i]) begin n_bad++; $display("FAIL crst_core_nrst c%0d: got %b want %b", i, core_nrst, exp_lvl[i]); end
      n_cmp++; if (cmd_ready !== exp_lvl[i]) begin n_bad++; $display("FAIL crst_cmd_ready c%0d: got %b want %b", i, cmd_ready, exp_lvl[i]); end
      n_cmp++; if (core_en !== 1'b0) begin n_bad++; $display("FAIL crst_core_en c%0d: got %b want 0", i, core_en); end
      @(posedge clk); #1;
    end
    n_cmp++; if (cyc_cnt !== 16'(exp_cyc)) begin n_bad++; $display("FAIL crst_cyc_cnt: got %0d want 0", cyc_cnt); end
  endtask

  task automatic test_mid_step_reset;
    int addrs [3];
    addrs = '{30, 31, 0};
    pc_i = 8'd0;
    cmd(OP_STEP, 16'd200);
    repeat (5) @(posedge clk);
    #1;
    nrst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL mrst_running: got %b want 0", running); end
    n_cmp++; if (core_en !== 1'b0) begin n_bad++; $display("FAIL mrst_core_en: got %b want 0", core_en); end
    n_cmp++; if (cyc_cnt !== 16'd0) begin n_bad++; $display("FAIL mrst_cyc_cnt: got %0d want 0", cyc_cnt); end
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    n_cmp++; if (core_nrst !== 1'b0) begin n_bad++; $display("FAIL mrst_core_nrst_hold: got %b want 0", core_nrst); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (core_nrst !== 1'b1) begin n_bad++; $display("FAIL mrst_core_nrst_rel: got %b want 1", core_nrst); end
    n_cmp++; if (core_en !== 1'b0) begin n_bad++; $display("FAIL mrst_core_en_after: got %b want 0", core_en); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      pc_i = 8'(addrs[i]);
      exp_q.push_back(model_mem[addrs[i]]);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_cmp++; if (inst_o !== exp) begin n_bad++; $display("FAIL mrst_mem_kept pc=%0d: got %h want %h", addrs[i], inst_o, exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_step();
    test_breakpoint();
    test_halt();
    test_core_rst();
    test_mid_step_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adel_seq_ctrl.md
Name: adel_seq_ctrl

Overview:
- Run-control sequencer and program store for the adel 8-bit core. Holds instruction memory, serves it combinationally on the core's pc, and gates core execution.
- Host-side command channel (valid/ready) for program load, run, halt, N-cycle step, breakpoint and core reset.
- Output core_en drives an external integrated clock-gate cell on the core clock. core_nrst drives the core's reset.

Parameters:
- DEPTH, 32, instruction words in program store (power of 2, 2..256); address = low log2(DEPTH) bits of any 8-bit address.
- CW, 16, width of executed-cycle counter.

Ports:
- clk  in  1  system clock, also the core clock before gating
- nrst  in  1  synchronous active-low reset
- cmd_valid  in  1  command presented
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge
- cmd_op  in  3  0 NOP, 1 SET_WPTR, 2 WRITE, 3 RUN, 4 HALT, 5 STEP, 6 SET_BP, 7 CORE_RST
- cmd_data  in  16  command operand
- pc_i  in  8  core program counter
- inst_o  out  16  instruction to core = mem[pc_i mod DEPTH], combinational
- core_en  out  1  core clock enable for the next edge
- core_nrst  out  1  registered core reset, active-low
- running  out  1  state is RUN or STEP
- bp_hit  out  1  sticky: last stop was caused by breakpoint
- cmd_err  out  1  one-cycle pulse: accepted command was illegal in current state
- cyc_cnt  out  CW  count of enabled core cycles, wraps

Behaviour:
- Reset (nrst=0 at posedge):
  - state=IDLE, wptr=0, bp_en=0, bp_addr=0, step_cnt=0, cyc_cnt=0, bp_hit=0, cmd_err=0, first=0.
  - core_nrst=0, and it stays 0 for the first posedge after nrst returns high.
  - Program memory is not reset; contents survive nrst.
- States:
  - IDLE: core_en=0.
  - RUN: core_en=1 unless breakpoint.
  - STEP: core_en=1 unless breakpoint.
  - CRST: core_en=0, core_nrst=0.
- Handshake:
  - cmd_ready=1 in IDLE, RUN and STEP; 0 in CRST. Data is sampled on the accepting edge.
- Command effects (state at the accepting edge):
  - SET_WPTR: IDLE only; wptr=cmd_data[7:0] mod DEPTH.
  - WRITE: IDLE only; mem[wptr]=cmd_data; wptr++ wraps DEPTH-1 -> 0. A WRITE to the address currently on pc_i is visible on inst_o the next cycle.
  - RUN: IDLE only; state=RUN, first=1, bp_hit=0.
  - HALT: RUN/STEP -> IDLE. The cycle in which HALT is presented is still enabled; no enabled cycles follow. HALT in IDLE is a legal no-op.
  - STEP: IDLE only; N=cmd_data[7:0]. N=0 is a legal no-op. Otherwise state=STEP, step_cnt=N, first=1, bp_hit=0.
  - SET_BP: any accepting state; bp_addr=cmd_data[7:0], bp_en=cmd_data[8]. Takes effect on the next cycle.
  - CORE_RST: IDLE only; state=CRST for 2 cycles with core_nrst=0, then IDLE with core_nrst=1. cyc_cnt is cleared on entry.
  - Any illegal op/state pair is accepted, causes no state change, and pulses cmd_err for one cycle.
- Breakpoint:
  - bp_match = bp_en & (pc_i==bp_addr) & !first, in RUN or STEP.
  - On a match: core_en=0 that cycle, so the instruction at bp_addr is not executed. Next state=IDLE, bp_hit=1.
  - first clears after the first cycle in RUN/STEP, so RUN or STEP from a breakpoint executes it.
- STEP:
  - Each enabled cycle decrements step_cnt.
  - The enabled cycle with step_cnt==1 is the last: next state=IDLE.
  - A breakpoint match wins over step completion.
- core_en=1 counts as one executed cycle: cyc_cnt += 1.
- Simultaneous events:
  - Breakpoint match and HALT accepted in the same cycle: core_en=0, IDLE, bp_hit=1.
  - nrst=0 overrides everything, including mid-STEP and mid-CRST.
- No register is written on the core's behalf; the core pc is observed only through pc_i.

Test Plan:
- Load: SET_WPTR 30, then WRITE A,B,C,D (DEPTH=32) -> mem[30]=A, mem[31]=B, mem[0]=C, mem[1]=D, wptr=2. Drive pc_i=31 -> inst_o=B.
- STEP 3 from IDLE -> core_en high exactly 3 cycles, running falls after, cyc_cnt=3. STEP 0 -> no enabled cycles, cmd_err=0.
- RUN with bp_en=1, bp_addr=5, pc_i sweeping 0..5 -> core_en=0 when pc_i=5, state IDLE, bp_hit=1. Second RUN at pc_i=5 -> core_en=1 that cycle, bp_hit=0.
- RUN, then HALT after 10 cycles -> cyc_cnt=11 including the HALT cycle. WRITE presented during RUN -> cmd_err pulse, mem unchanged.
- CORE_RST in IDLE -> core_nrst low exactly 2 cycles, cmd_ready low in those cycles, cyc_cnt=0.
- nrst low mid-STEP (N=200) -> IDLE, core_en=0, core_nrst low through first post-reset edge, memory contents unchanged.
